counter_mod100: RTL and testbench

- Free-running modulo-100 up-counter with two architecturally independent count registers exposed side by side.
- o_cnt is produced by a count register plus combinational next-state logic. o_cnt_always is produced by a second register updated entirely inside one sequential process.
- Both must track identically every cycle. The block serves as a timing/sequence source and as a cross-check of two counter coding styles.

---
 rtl/counter_mod100.sv | 50 +++++
 tb/tb_counter_mod100.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/counter_mod100.sv
// Free-running modulo-CNT_MAX up-counter built twice: once as register plus
// next-state logic, once as a single clocked process. Both must agree every cycle.
module counter_mod100 #(
    parameter int CNT_MAX   = 100,
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic [CNT_WIDTH-1:0] o_cnt_always
);

    // reset_n is active-high despite its name.
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CNT_MAX - 1);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cntAlways_q;

    // Using >= rather than == also recovers any out-of-range value in one edge.
    always_comb begin
        cnt_d = cnt_q + ONE;
        if (cnt_q >= LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            cntAlways_q <= '0;
        end else if (cntAlways_q >= LAST) begin
            cntAlways_q <= '0;
        end else begin
            cntAlways_q <= cntAlways_q + ONE;
        end
    end

    assign o_cnt        = cnt_q;
    assign o_cnt_always = cntAlways_q;

endmodule

// File: tb/tb_counter_mod100.sv
// Self-checking bench for counter_mod100: table-driven vectors, hand-written
// reset corner cases and randomized reset/run segments against an edge-count model.
module tb_counter_mod100;

   localparam int CNT_MAX   = 100;
   localparam int CNT_WIDTH = 7;

   logic                 clk;
   logic                 reset_n;
   logic [CNT_WIDTH-1:0] o_cnt;
   logic [CNT_WIDTH-1:0] o_cnt_always;

   int vectors;
   int miscompares;

   // Reference model: number of rising edges seen since the last release.
   bit inReset;
   int sinceRelease;

   typedef struct {
      logic rst;
      int   edges;
      int   expCnt;
   } vec_t;

   vec_t vecs[6];

   counter_mod100 #(
      .CNT_MAX   (CNT_MAX),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .o_cnt        (o_cnt),
      .o_cnt_always (o_cnt_always)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int modelValue();
      return inReset ? 0 : (sinceRelease % CNT_MAX);
   endfunction

   // Compares both count outputs against an expected value.
   task automatic checkOutput(input string name, input int expVal);
      logic [CNT_WIDTH-1:0] expCnt;
      expCnt = CNT_WIDTH'(expVal);
      vectors++;
      if (o_cnt !== expCnt) begin
         miscompares++;
         $display("[TB] FAIL %s o_cnt: got %0d expected %0d at %0t", name, o_cnt, expCnt, $time);
      end
      vectors++;
      if (o_cnt_always !== expCnt) begin
         miscompares++;
         $display("[TB] FAIL %s o_cnt_always: got %0d expected %0d at %0t", name, o_cnt_always, expCnt, $time);
      end
   endtask

   // Drives reset_n, then runs a number of rising edges checking every falling edge.
   // Must be called with no rising edge pending before its first wait.
   task automatic applyStimulus(input logic rst, input int edges);
      reset_n = rst;
      if (rst) begin
         inReset      = 1'b1;
         sinceRelease = 0;
      end else begin
         inReset = 1'b0;
      end
      #1;
      checkOutput("apply_start", modelValue());
      for (int e = 0; e < edges; e++) begin
         @(posedge clk);
         if (!inReset) sinceRelease++;
         @(negedge clk);
         checkOutput("apply_edge", modelValue());
      end
   endtask

   initial begin
      int runLen;
      vectors      = 0;
      miscompares  = 0;
      inReset      = 1'b0;
      sinceRelease = 0;

      vecs[0] = '{rst: 1'b1, edges: 10,  expCnt: 0};
      vecs[1] = '{rst: 1'b0, edges: 5,   expCnt: 5};
      vecs[2] = '{rst: 1'b0, edges: 94,  expCnt: 99};
      vecs[3] = '{rst: 1'b0, edges: 1,   expCnt: 0};
      vecs[4] = '{rst: 1'b0, edges: 1,   expCnt: 1};
      vecs[5] = '{rst: 1'b0, edges: 148, expCnt: 49};

      // Power-up: first reset assertion at 1 ns, outputs must be 0 (not X) right after.
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      inReset = 1'b1;
      #1;
      checkOutput("powerup", 0);

      // Table: reset hold, release, count to 99, wrap, run to 249 edges total.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].edges);
         checkOutput($sformatf("table%0d", i), vecs[i].expCnt);
      end

      // Async reset at count 57, raised between edges.
      applyStimulus(1'b1, 2);
      applyStimulus(1'b0, 57);
      checkOutput("mid_57", 57);
      #2;
      reset_n      = 1'b1;
      inReset      = 1'b1;
      sinceRelease = 0;
      #1;
      checkOutput("mid_async_clear", 0);
      @(negedge clk);
      applyStimulus(1'b1, 3);
      applyStimulus(1'b0, 0);
      checkOutput("mid_resume0", 0);
      applyStimulus(1'b0, 1);
      checkOutput("mid_resume1", 1);
      applyStimulus(1'b0, 1);
      checkOutput("mid_resume2", 2);

      // Short pulse: released for 10 ns spanning one edge, then held 2000 ns.
      applyStimulus(1'b1, 2);
      reset_n      = 1'b0;
      inReset      = 1'b0;
      sinceRelease = 0;
      @(posedge clk);
      sinceRelease++;
      #1;
      checkOutput("pulse_one", 1);
      @(negedge clk);
      applyStimulus(1'b1, 200);
      checkOutput("pulse_hold", 0);

      // Random run lengths with asynchronous reset raised mid-cycle.
      for (int r = 0; r < 20; r++) begin
         runLen = int'($urandom_range(1, 300));
         applyStimulus(1'b0, runLen);
         #($urandom_range(1, 3));
         reset_n      = 1'b1;
         inReset      = 1'b1;
         sinceRelease = 0;
         #1;
         checkOutput("rand_async_clear", 0);
         @(negedge clk);
         applyStimulus(1'b1, int'($urandom_range(1, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
